// File: rtl/rotary_pkg.sv
// Shared state encodings, direction constants and sizing helper for the
// rotary value controller.
package rotary_pkg;

  typedef enum logic {
    ST_SLOW = 1'b0,
    ST_FAST = 1'b1
  } accel_state_t;

  localparam logic DIR_CW  = 1'b1;
  localparam logic DIR_CCW = 1'b0;

  // Number of bits needed to encode 0..n-1, never less than one.
  function automatic int clog2(input int n);
    int bits;
    int span;
    bits = 32'sd0;
    span = 32'sd1;
    while (span < n) begin
      span = span * 32'sd2;
      bits = bits + 32'sd1;
    end
    return (bits < 32'sd1) ? 32'sd1 : bits;
  endfunction

endpackage

// File: rtl/rotary_accel_fsm.sv
// Speed detector: step-interval timer, quick-step streak counter and SLOW/FAST
// state; produces the step size for the value arithmetic.
module rotary_accel_fsm
  import rotary_pkg::*;
#(
  parameter int VALUE_WIDTH  = 8,
  parameter int ACCEL_WINDOW = 50000,
  parameter int ACCEL_STREAK = 3,
  parameter int ACCEL_STEP   = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_step,
  input  logic                   i_dir,
  input  logic                   i_clear,
  output logic                   o_fast,
  output logic [VALUE_WIDTH-1:0] o_delta
);

  localparam int TW = clog2(ACCEL_WINDOW + 1);
  localparam int SW = clog2(ACCEL_STREAK + 1);
  localparam logic [TW-1:0] TIMER_SAT   = TW'(ACCEL_WINDOW);
  localparam logic [SW-1:0] STREAK_FULL = SW'(ACCEL_STREAK);

  accel_state_t           state_r, state_s;
  logic [TW-1:0]          timer_r, timer_s;
  logic [SW-1:0]          streak_r, streak_s;
  logic                   last_dir_r, last_dir_s;
  logic                   quick_s;
  logic [VALUE_WIDTH-1:0] delta_s;

  // Next-state logic: clear dominates, then a step, otherwise idle timing.
  always_comb begin
    state_s    = state_r;
    timer_s    = timer_r;
    streak_s   = streak_r;
    last_dir_s = last_dir_r;
    delta_s    = VALUE_WIDTH'(1);
    quick_s    = (timer_r < TIMER_SAT) && (i_dir == last_dir_r);
    if (i_clear) begin
      state_s  = ST_SLOW;
      timer_s  = TIMER_SAT;
      streak_s = SW'(0);
    end else if (i_step) begin
      timer_s    = TW'(0);
      last_dir_s = i_dir;
      case (state_r)
        ST_SLOW: begin
          // The step completing the streak still moves by one.
          if (quick_s) begin
            streak_s = streak_r + SW'(1);
            if (streak_s == STREAK_FULL) state_s = ST_FAST;
            else state_s = ST_SLOW;
          end else begin
            streak_s = SW'(0);
          end
        end
        ST_FAST: begin
          if (quick_s) begin
            delta_s = VALUE_WIDTH'(ACCEL_STEP);
          end else begin
            state_s  = ST_SLOW;
            streak_s = SW'(0);
          end
        end
        default: begin
          state_s  = ST_SLOW;
          streak_s = SW'(0);
        end
      endcase
    end else begin
      if (timer_r < TIMER_SAT) timer_s = timer_r + TW'(1);
      else timer_s = TIMER_SAT;
      // Leave FAST on the same edge the timer reaches the window.
      if ((state_r == ST_FAST) && (timer_s == TIMER_SAT)) begin
        state_s  = ST_SLOW;
        streak_s = SW'(0);
      end else begin
        state_s = state_r;
      end
    end
  end

  // State, timer, streak and last-direction registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r    <= ST_SLOW;
      timer_r    <= TIMER_SAT;
      streak_r   <= SW'(0);
      last_dir_r <= DIR_CW;
    end else begin
      state_r    <= state_s;
      timer_r    <= timer_s;
      streak_r   <= streak_s;
      last_dir_r <= last_dir_s;
    end
  end

  assign o_fast  = (state_r == ST_FAST);
  assign o_delta = delta_s;

endmodule

// File: rtl/rotary_value_ctrl.sv
// Bounded user-parameter register driven by encoder steps, with load port and saturate/wrap range.
// Acceleration is built only when ROTARY_ACCEL_EN is defined.
module rotary_value_ctrl
  import rotary_pkg::*;
#(
  parameter int VALUE_WIDTH  = 8,
  parameter int VALUE_MIN    = 0,
  parameter int VALUE_MAX    = 255,
  parameter int VALUE_RESET  = 0,
  parameter int WRAP         = 0,
  parameter int ACCEL_WINDOW = 50000,
  parameter int ACCEL_STREAK = 3,
  parameter int ACCEL_STEP   = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_cnt,
  input  logic                   i_cnt_cw,
  input  logic                   i_load,
  input  logic [VALUE_WIDTH-1:0] i_load_value,
  output logic [VALUE_WIDTH-1:0] o_value,
  output logic                   o_changed,
  output logic                   o_at_min,
  output logic                   o_at_max,
  output logic                   o_fast
);

  localparam int XW = VALUE_WIDTH + 2;
  localparam logic signed [XW-1:0]  MIN_X   = XW'(VALUE_MIN);
  localparam logic signed [XW-1:0]  MAX_X   = XW'(VALUE_MAX);
  localparam logic signed [XW-1:0]  RANGE_X = XW'(VALUE_MAX - VALUE_MIN + 1);
  localparam logic [VALUE_WIDTH-1:0] MIN_V   = VALUE_WIDTH'(VALUE_MIN);
  localparam logic [VALUE_WIDTH-1:0] MAX_V   = VALUE_WIDTH'(VALUE_MAX);
  localparam logic [VALUE_WIDTH-1:0] RESET_V = VALUE_WIDTH'(VALUE_RESET);

  if (!((VALUE_MIN >= 32'sd0) && (VALUE_MIN < VALUE_MAX) &&
        (VALUE_MAX < (32'sd1 <<< VALUE_WIDTH)) &&
        (VALUE_RESET >= VALUE_MIN) && (VALUE_RESET <= VALUE_MAX) &&
        ((WRAP == 32'sd0) || (WRAP == 32'sd1)) &&
        (ACCEL_WINDOW > 32'sd0) && (ACCEL_STREAK > 32'sd0) &&
        (ACCEL_STEP > 32'sd1) && (ACCEL_STEP <= VALUE_MAX - VALUE_MIN))) begin : g_bad_cfg
    $error("rotary_value_ctrl: illegal parameter combination");
  end

  logic                   cw_s;
  logic                   fast_s;
  logic [VALUE_WIDTH-1:0] delta_s;
  logic [VALUE_WIDTH-1:0] value_r, next_s;
  logic signed [XW-1:0]   cand_s, adj_s;
  logic                   changed_r, at_min_r, at_max_r;

  assign cw_s = (i_cnt_cw != DIR_CCW);

`ifdef ROTARY_ACCEL_EN
  logic step_s;
  // A load drops a coincident step, so the detector never sees it.
  assign step_s = i_cnt & ~i_load;

  rotary_accel_fsm #(
    .VALUE_WIDTH  (VALUE_WIDTH),
    .ACCEL_WINDOW (ACCEL_WINDOW),
    .ACCEL_STREAK (ACCEL_STREAK),
    .ACCEL_STEP   (ACCEL_STEP)
  ) u_accel (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_step  (step_s),
    .i_dir   (i_cnt_cw),
    .i_clear (i_load),
    .o_fast  (fast_s),
    .o_delta (delta_s)
  );
`else
  assign delta_s = VALUE_WIDTH'(1);
  assign fast_s  = 1'b0;
`endif

  // Candidate value from load or step, then clamp (or wrap a step overshoot).
  always_comb begin
    if (i_load) begin
      cand_s = $signed({2'b00, i_load_value});
    end else if (i_cnt) begin
      if (cw_s) cand_s = $signed({2'b00, value_r}) + $signed({2'b00, delta_s});
      else cand_s = $signed({2'b00, value_r}) - $signed({2'b00, delta_s});
    end else begin
      cand_s = $signed({2'b00, value_r});
    end
    adj_s = cand_s;
    if (cand_s > MAX_X) begin
      if ((WRAP != 32'sd0) && !i_load) adj_s = cand_s - RANGE_X;
      else adj_s = MAX_X;
    end else if (cand_s < MIN_X) begin
      if ((WRAP != 32'sd0) && !i_load) adj_s = cand_s + RANGE_X;
      else adj_s = MIN_X;
    end else begin
      adj_s = cand_s;
    end
    next_s = VALUE_WIDTH'(adj_s);
  end

  // Value register with its change strobe and limit flags.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      value_r   <= RESET_V;
      changed_r <= 1'b0;
      at_min_r  <= (RESET_V == MIN_V);
      at_max_r  <= (RESET_V == MAX_V);
    end else begin
      value_r   <= next_s;
      changed_r <= (next_s != value_r);
      at_min_r  <= (next_s == MIN_V);
      at_max_r  <= (next_s == MAX_V);
    end
  end

  assign o_value   = value_r;
  assign o_changed = changed_r;
  assign o_at_min  = at_min_r;
  assign o_at_max  = at_max_r;
  assign o_fast    = fast_s;

endmodule
